// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller: edge-latched sources, req/ack handshake, in-service tracking.
// Optional non-maskable source enabled with `define NMI_EN (adds nmi_in, vector 16'hFFFC, id 4'hF).
module int_ctrl #(
    parameter int unsigned NUM_IRQ  = 14,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               GIE,
`ifdef NMI_EN
    input  logic               nmi_in,
`endif
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [15:0]        int_vec,
    output logic [3:0]         int_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [3:0]         sel;
    logic [15:0]        vec_sel;
    logic               ack_take;

`ifdef NMI_EN
    logic nmi_prev;
    logic nmi_pend;
    logic nmi_active;
    logic mask_active;
    logic nmi_rise;
    logic nmi_clr;

    assign nmi_rise = nmi_in & ~nmi_prev;
    assign nmi_clr  = ack_take & (int_id == 4'hF);
`endif

    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending & irq_en;
    assign ack_take = (state == StReq) & int_ack;
    assign vec_sel  = VEC_BASE + {11'd0, sel, 1'b0};

    // Ascending scan so the highest set bit is the one left in sel.
    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) sel = 4'(i);
        end
    end

    // The NMI id (4'hF) never matches a maskable index, so it clears nothing here.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = ack_take & (int_id == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            irq_prev   <= '0;
            pending    <= '0;
            int_req    <= 1'b0;
            int_vec    <= 16'h0000;
            int_id     <= 4'd0;
            in_service <= 1'b0;
`ifdef NMI_EN
            nmi_prev    <= 1'b0;
            nmi_pend    <= 1'b0;
            nmi_active  <= 1'b0;
            mask_active <= 1'b0;
`endif
        end else begin
            irq_prev <= irq_in;
            // A new edge wins over a same-cycle acknowledge clear.
            pending  <= (pending & ~clr) | rise;
`ifdef NMI_EN
            nmi_prev <= nmi_in;
            nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_rise;
`endif
            unique case (state)
                StIdle: begin
`ifdef NMI_EN
                    if (nmi_pend && !nmi_active) begin
                        int_req <= 1'b1;
                        int_vec <= 16'hFFFC;
                        int_id  <= 4'hF;
                        state   <= StReq;
                    end else
`endif
                    if (GIE && |eligible) begin
                        int_req <= 1'b1;
                        int_vec <= vec_sel;
                        int_id  <= sel;
                        state   <= StReq;
                    end
                end
                StReq: begin
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= StService;
`ifdef NMI_EN
                        if (int_id == 4'hF) nmi_active  <= 1'b1;
                        else                mask_active <= 1'b1;
`endif
                    end
                end
                StService: begin
`ifdef NMI_EN
                    if (reti) begin
                        if (nmi_active) begin
                            nmi_active <= 1'b0;
                            if (!mask_active) begin
                                in_service <= 1'b0;
                                state      <= StIdle;
                            end
                        end else begin
                            mask_active <= 1'b0;
                            in_service  <= 1'b0;
                            state       <= StIdle;
                        end
                    end else if (nmi_pend && !nmi_active) begin
                        // Single-level nesting of NMI over a maskable handler.
                        int_req <= 1'b1;
                        int_vec <= 16'hFFFC;
                        int_id  <= 4'hF;
                        state   <= StReq;
                    end
`else
                    if (reti) begin
                        in_service <= 1'b0;
                        state      <= StIdle;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
